// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_pkg : ALU control codes, ID/EX capture record, register width |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package riscv_pkg;

  localparam int XLEN   = `DATA_SIZE;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_LUI  = 4'd0,
    ALU_LDST = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_AND  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SUB  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11
  } alu_ctrl_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    alu_ctrl_e         alu_ctrl;
    logic              src_a_pc;
    logic              src_b_imm;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } id_ex_t;

  function automatic logic is_shift(input alu_ctrl_e c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// +--------------------------------------------------------------------+
// | id_ex_stage_if : decode, bypass and EX-side signals of the ID/EX    |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

interface id_ex_stage_if #(
  parameter int DATA_W = `DATA_SIZE,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;
  logic [CTRL_W-1:0] id_alu_ctrl;
  logic              id_src_a_pc;
  logic              id_src_b_imm;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;
  logic [REG_AW-1:0] id_rd_addr;
  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_rd_addr;
  logic [DATA_W-1:0] exm_result;
  logic              mwb_reg_write;
  logic [REG_AW-1:0] mwb_rd_addr;
  logic [DATA_W-1:0] mwb_result;
  logic              ex_ready;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              load_use_bubble;

  modport master (
    output in_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
           id_mem_read, id_mem_write, id_reg_write, id_rd_addr,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result, ex_ready, stall, flush,
    input  in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_bubble
  );

  modport slave (
    input  in_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
           id_mem_read, id_mem_write, id_reg_write, id_rd_addr,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result, ex_ready, stall, flush,
    output in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_bubble
  );
endinterface

`default_nettype wire

// File: rtl/fwd_unit.sv
// +--------------------------------------------------------------------+
// | fwd_unit : single-operand bypass select (EX/MEM > MEM/WB > RF)      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    // x0 is hardwired: neither a stale RF value nor a bypass may leak through
    if (rs_addr == '0)
      fwd_data = '0;
    else if (exm_reg_write && (exm_rd_addr == rs_addr))
      fwd_data = exm_result;
    else if (mwb_reg_write && (mwb_rd_addr == rs_addr))
      fwd_data = mwb_result;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------+
// | id_ex_stage : ID/EX register, load-use bubble, operand forwarding   |
// | Optional    : ID_EX_PERF_CNT_EN adds bubble_cnt / flush_cnt         |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module id_ex_stage #(
  parameter int DATA_W = `DATA_SIZE,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);
  import riscv_pkg::*;

  id_ex_t            ex_q;
  id_ex_t            id_d;
  logic              ex_valid_q;
  logic              use_rs1;
  logic              use_rs2;
  logic              hazard;
  logic              capture;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;
  logic [DATA_W-1:0] b_raw;

  always_comb begin
    id_d           = '0;
    id_d.rs1_addr  = bus.id_rs1_addr;
    id_d.rs2_addr  = bus.id_rs2_addr;
    id_d.rd_addr   = bus.id_rd_addr;
    id_d.rs1_data  = bus.id_rs1_data;
    id_d.rs2_data  = bus.id_rs2_data;
    id_d.imm       = bus.id_imm;
    id_d.pc        = bus.id_pc;
    id_d.alu_ctrl  = alu_ctrl_e'(bus.id_alu_ctrl);
    id_d.src_a_pc  = bus.id_src_a_pc;
    id_d.src_b_imm = bus.id_src_b_imm;
    id_d.mem_read  = bus.id_mem_read;
    id_d.mem_write = bus.id_mem_write;
    id_d.reg_write = bus.id_reg_write;
  end

  // Stores read rs2 as store data even though operand B is the offset
  assign use_rs1 = ~bus.id_src_a_pc;
  assign use_rs2 = ~bus.id_src_b_imm | bus.id_mem_write;
  assign hazard  = ex_valid_q & ex_q.mem_read & (ex_q.rd_addr != '0) &
                   ((use_rs1 & (ex_q.rd_addr == bus.id_rs1_addr)) |
                    (use_rs2 & (ex_q.rd_addr == bus.id_rs2_addr)));

  assign bus.in_ready        = ~bus.stall & bus.ex_ready & ~hazard;
  assign bus.load_use_bubble = hazard;
  assign capture             = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (bus.ex_ready && !bus.stall) begin
      ex_valid_q <= capture;
      if (capture)
        ex_q <= id_d;
    end
  end

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr       (ex_q.rs1_addr),
    .rf_data       (ex_q.rs1_data),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd_addr   (bus.mwb_rd_addr),
    .mwb_result    (bus.mwb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr       (ex_q.rs2_addr),
    .rf_data       (ex_q.rs2_data),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd_addr   (bus.mwb_rd_addr),
    .mwb_result    (bus.mwb_result),
    .fwd_data      (fwd_rs2)
  );

  assign b_raw = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;

  assign bus.alu_a         = ex_q.src_a_pc ? ex_q.pc : fwd_rs1;
  assign bus.alu_b         = is_shift(ex_q.alu_ctrl) ? {{(DATA_W-5){1'b0}}, b_raw[4:0]} : b_raw;
  assign bus.alu_ctrl      = CTRL_W'(ex_q.alu_ctrl);
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_mem_read   = ex_q.mem_read;
  // Side-effecting controls are masked so a dead slot can never commit
  assign bus.ex_reg_write  = ex_valid_q & ex_q.reg_write;
  assign bus.ex_mem_write  = ex_valid_q & ex_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hazard)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (bus.flush && ex_valid_q)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the stage.
`default_nettype none

module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(4)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // reference model state of the EX slot
  logic        m_v, m_sa, m_sb, m_mr, m_mw, m_rw;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  logic [3:0]  m_ctrl;
  int unsigned m_bub, m_flc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_pc = 0;
    bus.id_alu_ctrl = 0; bus.id_src_a_pc = 0; bus.id_src_b_imm = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_reg_write = 0; bus.id_rd_addr = 0;
    bus.exm_reg_write = 0; bus.exm_rd_addr = 0; bus.exm_result = 0;
    bus.mwb_reg_write = 0; bus.mwb_rd_addr = 0; bus.mwb_result = 0;
    bus.ex_ready = 1; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [3:0] ctrl, input logic [31:0] imm,
                       input logic sb, input logic mr, input logic mw,
                       input logic [4:0] rd);
    bus.in_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2; bus.id_rs2_data = d2; bus.id_alu_ctrl = ctrl;
    bus.id_imm = imm; bus.id_pc = 32'h1000; bus.id_src_a_pc = 0; bus.id_src_b_imm = sb;
    bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_reg_write = !mw; bus.id_rd_addr = rd;
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (bus.exm_reg_write && bus.exm_rd_addr == rs) return bus.exm_result;
    if (bus.mwb_reg_write && bus.mwb_rd_addr == rs) return bus.mwb_result;
    return rf;
  endfunction

  task automatic test_reset();
    idle();
    issue(1, 32'h55, 2, 32'h66, ALU_XOR, 32'h9, 1, 1, 0, 7);
    tick();
    rst = 1; bus.stall = 1; bus.flush = 1;
    issue(3, 32'h77, 4, 32'h88, ALU_SUB, 32'h1, 0, 0, 1, 5);
    tick();
    idle();
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", bus.ex_valid); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.ex_store_data} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h %h %h exp=0", bus.alu_a, bus.alu_b, bus.ex_store_data); end
    checks++; if ({bus.alu_ctrl, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.load_use_bubble} !== 13'd0) begin failures++; $display("FAIL reset_ctrl got=%h/%h/%b%b%b%b exp=0", bus.alu_ctrl, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.load_use_bubble); end
    rst = 0;
    tick();
  endtask

  task automatic test_add();
    idle();
    issue(1, 32'd5, 2, 32'd7, ALU_ADD, 32'd0, 0, 0, 0, 3);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL add_ex_valid got=%b exp=1", bus.ex_valid); end
    checks++; if (bus.alu_a !== 32'd5) begin failures++; $display("FAIL add_alu_a got=%h exp=5", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'd7) begin failures++; $display("FAIL add_alu_b got=%h exp=7", bus.alu_b); end
    checks++; if (bus.alu_ctrl !== 4'd2) begin failures++; $display("FAIL add_alu_ctrl got=%h exp=2", bus.alu_ctrl); end
    checks++; if ({bus.ex_rd_addr, bus.ex_reg_write} !== {5'd3, 1'b1}) begin failures++; $display("FAIL add_rd got=%h/%b exp=3/1", bus.ex_rd_addr, bus.ex_reg_write); end
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    issue(3, 32'h11, 5, 32'h22, ALU_ADD, 32'd0, 0, 0, 0, 6);
    tick();
    bus.in_valid = 0;
    bus.exm_reg_write = 1; bus.exm_rd_addr = 3; bus.exm_result = 32'h100;
    bus.mwb_reg_write = 1; bus.mwb_rd_addr = 3; bus.mwb_result = 32'h200;
    #1;
    checks++; if (bus.alu_a !== 32'h100) begin failures++; $display("FAIL fwd_exm_priority got=%h exp=100", bus.alu_a); end
    bus.exm_reg_write = 0;
    #1;
    checks++; if (bus.alu_a !== 32'h200) begin failures++; $display("FAIL fwd_mwb got=%h exp=200", bus.alu_a); end
    bus.mwb_reg_write = 0;
    #1;
    checks++; if (bus.alu_a !== 32'h11) begin failures++; $display("FAIL fwd_rf got=%h exp=11", bus.alu_a); end
    bus.exm_reg_write = 1; bus.exm_rd_addr = 5; bus.exm_result = 32'h333;
    #1;
    checks++; if ({bus.alu_b, bus.ex_store_data} !== {32'h333, 32'h333}) begin failures++; $display("FAIL fwd_rs2 got=%h/%h exp=333/333", bus.alu_b, bus.ex_store_data); end
    issue(0, 32'h55, 0, 32'h66, ALU_ADD, 32'd0, 0, 0, 0, 6);
    tick();
    bus.in_valid = 0;
    bus.exm_reg_write = 1; bus.exm_rd_addr = 0; bus.exm_result = 32'hFFFF;
    bus.mwb_reg_write = 1; bus.mwb_rd_addr = 0; bus.mwb_result = 32'hFFFF;
    #1;
    checks++; if ({bus.alu_a, bus.ex_store_data} !== 64'd0) begin failures++; $display("FAIL fwd_x0 got=%h/%h exp=0/0", bus.alu_a, bus.ex_store_data); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    issue(1, 32'h40, 0, 32'd0, ALU_LDST, 32'd4, 1, 1, 0, 4);
    tick();
    issue(4, 32'hAA, 2, 32'd7, ALU_ADD, 32'd0, 0, 0, 0, 5);
    #1;
    checks++; if ({bus.in_ready, bus.load_use_bubble} !== 2'b01) begin failures++; $display("FAIL lu_detect got=ready%b bubble%b exp=ready0 bubble1", bus.in_ready, bus.load_use_bubble); end
    tick();
    checks++; if ({bus.ex_valid, bus.load_use_bubble, bus.in_ready} !== 3'b001) begin failures++; $display("FAIL lu_bubble got=valid%b bubble%b ready%b exp=0,0,1", bus.ex_valid, bus.load_use_bubble, bus.in_ready); end
    tick();
    bus.in_valid = 0;
    #1;
    checks++; if ({bus.ex_valid, bus.alu_ctrl, bus.ex_rd_addr} !== {1'b1, 4'd2, 5'd5}) begin failures++; $display("FAIL lu_capture got=%b/%h/%h exp=1/2/5", bus.ex_valid, bus.alu_ctrl, bus.ex_rd_addr); end
    tick();
  endtask

  task automatic test_flush_stall();
    idle();
    issue(1, 32'd5, 2, 32'd7, ALU_ADD, 32'd0, 0, 0, 0, 3);
    tick();
    bus.flush = 1; bus.stall = 1;
    issue(1, 32'd9, 2, 32'd9, ALU_XOR, 32'd0, 0, 0, 0, 9);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flst_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    bus.flush = 0; bus.stall = 0; bus.in_valid = 0;
    #1;
    checks++; if ({bus.ex_valid, bus.ex_reg_write} !== 2'b00) begin failures++; $display("FAIL flst_kill got=valid%b rw%b exp=0,0", bus.ex_valid, bus.ex_reg_write); end
    checks++; if ({bus.alu_ctrl, bus.ex_rd_addr} !== {4'd2, 5'd3}) begin failures++; $display("FAIL flst_nocapture got=%h/%h exp=2/3", bus.alu_ctrl, bus.ex_rd_addr); end
    issue(1, 32'd5, 2, 32'd7, ALU_ADD, 32'd0, 0, 0, 0, 3);
    tick();
    bus.flush = 1;
    issue(1, 32'd9, 2, 32'd9, ALU_XOR, 32'd0, 0, 0, 0, 9);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.flush = 0; bus.in_valid = 0;
    #1;
    checks++; if ({bus.ex_valid, bus.ex_rd_addr} !== {1'b0, 5'd3}) begin failures++; $display("FAIL flush_nocapture got=%b/%h exp=0/3", bus.ex_valid, bus.ex_rd_addr); end
    tick();
  endtask

  task automatic test_shift_lui();
    idle();
    issue(1, 32'd0, 0, 32'd0, ALU_SLL, 32'h25, 1, 0, 0, 2);
    tick();
    #1;
    checks++; if (bus.alu_b !== 32'h5) begin failures++; $display("FAIL slli_mask got=%h exp=5", bus.alu_b); end
    issue(0, 32'd0, 0, 32'd0, ALU_LUI, 32'hABCDE, 1, 0, 0, 2);
    tick();
    #1;
    checks++; if (bus.alu_b !== 32'h000ABCDE) begin failures++; $display("FAIL lui_imm got=%h exp=000abcde", bus.alu_b); end
    issue(1, 32'd0, 2, 32'hFFFFFFE3, ALU_SRA, 32'd0, 0, 0, 0, 2);
    tick();
    #1;
    checks++; if ({bus.alu_b, bus.ex_store_data} !== {32'h3, 32'hFFFFFFE3}) begin failures++; $display("FAIL sra_mask got=%h/%h exp=3/ffffffe3", bus.alu_b, bus.ex_store_data); end
    issue(1, 32'd0, 0, 32'd0, ALU_ADD, 32'h25, 1, 0, 0, 2);
    tick();
    bus.in_valid = 0;
    #1;
    checks++; if (bus.alu_b !== 32'h25) begin failures++; $display("FAIL addi_nomask got=%h exp=25", bus.alu_b); end
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    issue(1, 32'h111, 2, 32'h222, ALU_ADD, 32'd0, 0, 0, 0, 7);
    tick();
    issue(1, 32'h333, 2, 32'h444, ALU_SUB, 32'd0, 0, 0, 0, 8);
    bus.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.in_ready, bus.ex_valid, bus.alu_a, bus.alu_ctrl, bus.ex_rd_addr} !== {1'b0, 1'b1, 32'h111, 4'd2, 5'd7})
        begin failures++; $display("FAIL bp_hold[%0d] got=ready%b valid%b a=%h ctrl=%h rd=%h exp=0,1,111,2,7", i, bus.in_ready, bus.ex_valid, bus.alu_a, bus.alu_ctrl, bus.ex_rd_addr); end
      tick();
    end
    bus.ex_ready = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    #1;
    checks++; if ({bus.ex_valid, bus.alu_a, bus.alu_ctrl, bus.ex_rd_addr} !== {1'b1, 32'h333, 4'd9, 5'd8}) begin failures++; $display("FAIL bp_capture got=%b/%h/%h/%h exp=1/333/9/8", bus.ex_valid, bus.alu_a, bus.alu_ctrl, bus.ex_rd_addr); end
    tick();
  endtask

  task automatic test_random();
    logic        haz, e_ready;
    logic [31:0] e_a, e_b, e_sd;
    idle();
    rst = 1;
    tick();
    rst = 0;
    m_v = 0; m_bub = 0; m_flc = 0;
    for (int n = 0; n < 400; n++) begin
      bus.in_valid     = ($urandom % 5) != 0;
      bus.id_rs1_addr  = 5'($urandom_range(0, 3));
      bus.id_rs2_addr  = 5'($urandom_range(0, 3));
      bus.id_rs1_data  = $urandom;
      bus.id_rs2_data  = $urandom;
      bus.id_imm       = $urandom;
      bus.id_pc        = $urandom;
      bus.id_alu_ctrl  = 4'($urandom_range(0, 11));
      bus.id_src_a_pc  = ($urandom % 4) == 0;
      bus.id_src_b_imm = ($urandom % 2) == 0;
      bus.id_mem_read  = ($urandom % 3) == 0;
      bus.id_mem_write = !bus.id_mem_read && (($urandom % 4) == 0);
      bus.id_reg_write = ($urandom % 2) == 0;
      bus.id_rd_addr   = 5'($urandom_range(0, 3));
      bus.exm_reg_write = ($urandom % 2) == 0;
      bus.exm_rd_addr  = 5'($urandom_range(0, 3));
      bus.exm_result   = $urandom;
      bus.mwb_reg_write = ($urandom % 2) == 0;
      bus.mwb_rd_addr  = 5'($urandom_range(0, 3));
      bus.mwb_result   = $urandom;
      bus.ex_ready     = ($urandom % 6) != 0;
      bus.stall        = ($urandom % 8) == 0;
      bus.flush        = ($urandom % 12) == 0;
      #1;
      haz = m_v && m_mr && (m_rd != 0) &&
            ((!bus.id_src_a_pc && m_rd == bus.id_rs1_addr) ||
             ((!bus.id_src_b_imm || bus.id_mem_write) && m_rd == bus.id_rs2_addr));
      e_ready = !bus.stall && bus.ex_ready && !haz;
      e_a  = m_sa ? m_pc : ref_fwd(m_rs1, m_d1);
      e_sd = ref_fwd(m_rs2, m_d2);
      e_b  = m_sb ? m_imm : e_sd;
      if (m_ctrl >= 4'd6 && m_ctrl <= 4'd8) e_b = e_b % 32;
      checks++; if ({bus.in_ready, bus.load_use_bubble} !== {e_ready, haz}) begin failures++; $display("FAIL rnd_handshake[%0d] got=ready%b bubble%b exp=ready%b bubble%b", n, bus.in_ready, bus.load_use_bubble, e_ready, haz); end
      checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write} !== {m_v, m_v & m_rw, m_v & m_mw}) begin failures++; $display("FAIL rnd_valid[%0d] got=%b%b%b exp=%b%b%b", n, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write, m_v, m_v & m_rw, m_v & m_mw); end
      if (m_v) begin
        checks++; if ({bus.alu_a, bus.alu_b, bus.ex_store_data} !== {e_a, e_b, e_sd}) begin failures++; $display("FAIL rnd_operands[%0d] got=%h/%h/%h exp=%h/%h/%h", n, bus.alu_a, bus.alu_b, bus.ex_store_data, e_a, e_b, e_sd); end
        checks++; if ({bus.alu_ctrl, bus.ex_rd_addr, bus.ex_mem_read} !== {m_ctrl, m_rd, m_mr}) begin failures++; $display("FAIL rnd_ctrl[%0d] got=%h/%h/%b exp=%h/%h/%b", n, bus.alu_ctrl, bus.ex_rd_addr, bus.ex_mem_read, m_ctrl, m_rd, m_mr); end
      end
      if (haz) m_bub++;
      if (bus.flush && m_v) m_flc++;
      if (bus.flush) m_v = 0;
      else if (bus.ex_ready && !bus.stall) begin
        if (bus.in_valid && e_ready) begin
          m_rs1 = bus.id_rs1_addr; m_rs2 = bus.id_rs2_addr; m_rd = bus.id_rd_addr;
          m_d1 = bus.id_rs1_data; m_d2 = bus.id_rs2_data; m_imm = bus.id_imm; m_pc = bus.id_pc;
          m_ctrl = bus.id_alu_ctrl; m_sa = bus.id_src_a_pc; m_sb = bus.id_src_b_imm;
          m_mr = bus.id_mem_read; m_mw = bus.id_mem_write; m_rw = bus.id_reg_write;
        end
        m_v = bus.in_valid && e_ready;
      end
      tick();
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++; if ({bubble_cnt, flush_cnt} !== {m_bub, m_flc}) begin failures++; $display("FAIL perf_cnt got=%0d/%0d exp=%0d/%0d", bubble_cnt, flush_cnt, m_bub, m_flc); end
`endif
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_add();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    test_shift_lui();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end that feeds the 4-bit-controlled ALU in the EX stage.
- Captures decoded operands, immediate, PC and ALU control from decode, and holds them for one EX cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, inserts a one-cycle bubble on load-use, and honours stall and flush from the hazard and branch logic.

Parameters:
- DATA_W, `data_size (32): operand/result width.
- REG_AW, 5: register address width.
- CTRL_W, 4: ALU control width; codes are defined in the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts it this cycle
- id_rs1_addr, id_rs2_addr  in  REG_AW  source registers
- id_rs1_data, id_rs2_data  in  DATA_W  register-file values (RF is write-first)
- id_imm  in  DATA_W  immediate; for LUI, the 20-bit U-imm right-aligned
- id_pc  in  DATA_W  instruction PC
- id_alu_ctrl  in  CTRL_W  ALU operation code
- id_src_a_pc  in  1  operand A = PC instead of rs1
- id_src_b_imm  in  1  operand B = imm instead of rs2
- id_mem_read, id_mem_write, id_reg_write  in  1  load / store / writes rd
- id_rd_addr  in  REG_AW  destination register
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd_addr  in  REG_AW  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB writes a register
- mwb_rd_addr  in  REG_AW  MEM/WB destination
- mwb_result  in  DATA_W  MEM/WB writeback value
- ex_ready  in  1  EX/MEM can take the EX instruction
- stall  in  1  external hold
- flush  in  1  kill EX and the incoming instruction
- ex_valid  out  1  EX slot holds a valid instruction
- alu_a, alu_b  out  DATA_W  forwarded ALU operands
- alu_ctrl  out  CTRL_W  registered control
- ex_store_data  out  DATA_W  forwarded rs2 value for stores
- ex_rd_addr  out  REG_AW; ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- load_use_bubble  out  1  bubble inserted this cycle

Behaviour:
- Reset: on rst=1 at a clk edge, all registered fields go to 0; ex_valid=0, alu_ctrl=0, and all outputs read 0. rst overrides flush and stall.
- Capture rule: capture = in_valid & in_ready. in_ready = ~stall & ex_ready & ~hazard. Latency is 1 cycle from capture to ex_valid=1.
- Hold: if ~ex_ready or stall, all EX registers hold and ex_valid holds.
- Bubble: if ex_ready & ~stall & ~capture, ex_valid goes to 0.
- Flush: flush=1 clears ex_valid next cycle and the incoming instruction is not captured (in_ready is still reported). flush beats stall, hold and hazard.
- Load-use hazard, combinational: hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & (rd==rs1 used | rd==rs2 used).
  - rs1 is used unless id_src_a_pc. rs2 is used unless id_src_b_imm, except that stores always use rs2.
  - On hazard: in_ready=0, load_use_bubble=1, and EX advances as a bubble. The bubble lasts exactly 1 cycle.
- Forwarding is combinational in EX on the registered rs addresses. For each source:
  - EX/MEM has priority when exm_reg_write & exm_rd_addr==rs & rs!=0.
  - Otherwise MEM/WB when mwb_reg_write & mwb_rd_addr==rs & rs!=0.
  - Otherwise the registered RF data.
  - x0 is never forwarded and always reads 0.
- Operand mux:
  - alu_a = src_a_pc ? pc : fwd_rs1.
  - alu_b = src_b_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Shifts: for alu_ctrl codes SLL/SRL/SRA (6/7/8), alu_b is zero-extended from its bits [4:0].
- LUI (code 0): imm passes through unmodified.
- Invalid slot: when ex_valid=0, ex_reg_write and ex_mem_write read 0 regardless of the register contents.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined: adds outputs bubble_cnt[31:0] and flush_cnt[31:0].
  - bubble_cnt increments on each load_use_bubble cycle.
  - flush_cnt increments on each flush cycle in which ex_valid=1.
  - Both counters clear on rst and wrap at 2^32.
- When undefined: neither port nor any counter logic exists.

Decomposition:
- Package riscv_pkg holds:
  - the alu_ctrl_e enum for codes 0..11 (LUI, LDST, ADD, XOR, OR, AND, SLL, SRL, SRA, SUB, SLT, SLTU);
  - the id_ex_t struct for the captured fields;
  - the REG_AW constant.
- DATA_W stays tied to `data_size.
- Sub-module fwd_unit: a purely combinational single-operand forwarding selector, instantiated twice (rs1, rs2).

Test Plan:
- Reset then single ADD: rs1=x1=5, rs2=x2=7, ctrl=2, no hazards -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_ctrl=2.
- Back-to-back RAW:
  - exm writes x3=0x100 and mwb writes x3=0x200 while EX reads x3 -> alu_a=0x100 (EX/MEM priority).
  - With only mwb writing -> alu_a=0x200.
  - rd=x0 with result 0xFFFF -> alu_a=0.
- Load-use: EX holds LW x4, decode issues ADD using x4 -> in_ready=0 and load_use_bubble=1 for exactly 1 cycle; ex_valid=0 the next cycle; ADD captured the cycle after.
- Flush with stall: flush=1, stall=1, ex_valid=1 -> ex_valid=0 next cycle; ex_reg_write=0; nothing captured.
- Shift mask: SLLI with imm=0x25 -> alu_b=0x5. LUI with imm=0xABCDE -> alu_b=0x000ABCDE.
- Backpressure: ex_ready=0 for 3 cycles -> all outputs stable and in_ready=0; ex_ready=1 -> next instruction captured.
